// File: rtl/cmplx_mult_sm.sv
// Switch/LED front end for a signed fixed-point complex multiplier (four words in, re/im out).
// Optional SM_DEBOUNCE_EN: handshake must stay high DEBOUNCE_CYCLES cycles before an event fires.
module cmplx_mult_sm #(
  parameter int WORD_W          = 8,
  parameter int FRAC_BITS       = WORD_W - 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic [WORD_W+1:0] SW,
  output logic [WORD_W-1:0] LED
);

  localparam int FULL_W = 2 * WORD_W + 1;
  localparam logic signed [FULL_W-1:0] SAT_MAX = {{(FULL_W-WORD_W+1){1'b0}}, {(WORD_W-1){1'b1}}};
  localparam logic signed [FULL_W-1:0] SAT_MIN = ~SAT_MAX;

  if (FRAC_BITS < 0 || FRAC_BITS >= FULL_W || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("cmplx_mult_sm: unsupported FRAC_BITS/DEBOUNCE_CYCLES");
  end

  typedef enum logic [2:0] {
    LOAD_RE_A = 3'd0,
    LOAD_IM_A = 3'd1,
    LOAD_RE_Q = 3'd2,
    LOAD_IM_Q = 3'd3,
    SHOW_RE   = 3'd4,
    SHOW_IM   = 3'd5
  } state_t;

  function automatic logic signed [FULL_W-1:0] sext(input logic signed [WORD_W-1:0] v);
    return {{(FULL_W-WORD_W){v[WORD_W-1]}}, v};
  endfunction

  function automatic logic [WORD_W-1:0] sat(input logic signed [FULL_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[WORD_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[WORD_W-1:0];
    end else begin
      return v[WORD_W-1:0];
    end
  endfunction

  logic                     rst_n_s;
  logic                     hs_s;
  logic signed [WORD_W-1:0] data_s;
  logic                     sync1_r;
  logic                     sync2_r;
  logic                     event_s;
  state_t                   state_r;
  state_t                   state_next_s;
  logic signed [WORD_W-1:0] re_a_r;
  logic signed [WORD_W-1:0] im_a_r;
  logic signed [WORD_W-1:0] re_q_r;
  logic signed [WORD_W-1:0] im_q_r;
  logic                     compute_r;
  logic signed [FULL_W-1:0] pr_full_s;
  logic signed [FULL_W-1:0] pi_full_s;
  logic signed [FULL_W-1:0] pr_shift_s;
  logic signed [FULL_W-1:0] pi_shift_s;
  logic        [WORD_W-1:0] res_re_r;
  logic        [WORD_W-1:0] res_im_r;

  assign rst_n_s = SW[WORD_W+1];
  assign hs_s    = SW[WORD_W];
  assign data_s  = SW[WORD_W-1:0];

  // Two-flop synchronizer on the asynchronous handshake switch
  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= hs_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef SM_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CNT_W-1:0] db_cnt_r;

  // Counts consecutive high samples; parks at DEBOUNCE_CYCLES so one high period fires once
  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      db_cnt_r <= '0;
    end else if (!sync2_r) begin
      db_cnt_r <= '0;
    end else if (db_cnt_r != CNT_W'(DEBOUNCE_CYCLES)) begin
      db_cnt_r <= db_cnt_r + CNT_W'(1);
    end else begin
      db_cnt_r <= db_cnt_r;
    end
  end

  assign event_s = sync2_r && (db_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1));
`else
  logic prev_r;

  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sync2_r;
    end
  end

  assign event_s = sync2_r & ~prev_r;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      state_r <= LOAD_RE_A;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    if (event_s) begin
      case (state_r)
        LOAD_RE_A: state_next_s = LOAD_IM_A;
        LOAD_IM_A: state_next_s = LOAD_RE_Q;
        LOAD_RE_Q: state_next_s = LOAD_IM_Q;
        LOAD_IM_Q: state_next_s = SHOW_RE;
        SHOW_RE:   state_next_s = SHOW_IM;
        SHOW_IM:   state_next_s = LOAD_IM_A;
        default:   state_next_s = LOAD_RE_A;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // SHOW_IM doubles as the re_a slot so consecutive products need no extra strobe
  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      re_a_r    <= '0;
      im_a_r    <= '0;
      re_q_r    <= '0;
      im_q_r    <= '0;
      compute_r <= 1'b0;
    end else begin
      compute_r <= event_s && (state_r == LOAD_IM_Q);
      if (event_s) begin
        case (state_r)
          LOAD_RE_A, SHOW_IM: re_a_r <= data_s;
          LOAD_IM_A:          im_a_r <= data_s;
          LOAD_RE_Q:          re_q_r <= data_s;
          LOAD_IM_Q:          im_q_r <= data_s;
          default: begin
          end
        endcase
      end
    end
  end

  // Full-precision products; >>> on a signed value floors toward -inf
  always_comb begin
    pr_full_s  = sext(re_a_r) * sext(re_q_r) - sext(im_a_r) * sext(im_q_r);
    pi_full_s  = sext(re_a_r) * sext(im_q_r) + sext(im_a_r) * sext(re_q_r);
    pr_shift_s = pr_full_s >>> FRAC_BITS;
    pi_shift_s = pi_full_s >>> FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      res_re_r <= '0;
      res_im_r <= '0;
    end else if (compute_r) begin
      res_re_r <= sat(pr_shift_s);
      res_im_r <= sat(pi_shift_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_s) begin
      LED <= '0;
    end else begin
      case (state_r)
        SHOW_RE: LED <= res_re_r;
        SHOW_IM: LED <= res_im_r;
        default: LED <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cmplx_mult_sm.sv
// Directed bench for cmplx_mult_sm: behavioural operand/phase model plus literal result checks.
module tb_cmplx_mult_sm;

  logic       clk = 1'b0;
  logic [9:0] SW;
  logic [7:0] LED;

`ifdef SM_DEBOUNCE_EN
  localparam int HOLD = 24;
`else
  localparam int HOLD = 6;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         valid    = 1'b0;
  logic [7:0] exp_led  = 8'h00;
  int         phase    = 0;
  int         ra = 0, ia = 0, rq = 0, iq = 0;

  cmplx_mult_sm dut (.clk(clk), .SW(SW), .LED(LED));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Real product, floor of value/128, clamped to the signed 8-bit range
  function automatic logic [7:0] q17_result(input int p);
    real r;
    int  v;
    r = $floor(real'(p) / 128.0);
    v = int'(r);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  task automatic model_event(input logic [7:0] d);
    int sd;
    sd = int'($signed(d));
    case (phase)
      0: begin ra = sd; phase = 1; end
      1: begin ia = sd; phase = 2; end
      2: begin rq = sd; phase = 3; end
      3: begin iq = sd; phase = 4; end
      4: phase = 5;
      5: begin ra = sd; phase = 1; end
      default: phase = 0;
    endcase
    if (phase == 4)      exp_led = q17_result(ra * rq - ia * iq);
    else if (phase == 5) exp_led = q17_result(ra * iq + ia * rq);
    else                 exp_led = 8'h00;
  endtask

  task automatic strobe(input logic [7:0] d, input int hold);
    valid = 1'b0;
    @(negedge clk);
    SW[7:0] = d;
    SW[8]   = 1'b1;
    repeat (hold) @(negedge clk);
    SW[8] = 1'b0;
    repeat (12) @(negedge clk);
    model_event(d);
    valid = 1'b1;
  endtask

  task automatic glitch(input logic [7:0] d, input int hold);
    valid = 1'b0;
    @(negedge clk);
    SW[7:0] = d;
    SW[8]   = 1'b1;
    repeat (hold) @(negedge clk);
    SW[8] = 1'b0;
    repeat (30) @(negedge clk);
    valid = 1'b1;
  endtask

  task automatic pulse_reset();
    valid = 1'b0;
    @(negedge clk);
    SW[9] = 1'b0;
    SW[8] = 1'b0;
    @(negedge clk);
    SW[9] = 1'b1;
    phase = 0; ra = 0; ia = 0; rq = 0; iq = 0; exp_led = 8'h00;
    repeat (2) @(negedge clk);
    valid = 1'b1;
  endtask

  task automatic enter4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    strobe(a, HOLD);
    strobe(b, HOLD);
    strobe(c, HOLD);
    strobe(e, HOLD);
  endtask

  always @(negedge clk) begin
    if (valid) check("led_vs_model", LED, exp_led);
  end

  initial begin
    SW = 10'h000;
    repeat (3) @(negedge clk);
    check("reset_led", LED, 8'h00);
    SW[9] = 1'b1;
    valid = 1'b1;
    repeat (2) @(negedge clk);

    enter4(8'h40, 8'h40, 8'h40, 8'h00);
    check("half_sq_re", LED, 8'h20);
    check("model_half_sq_re", exp_led, 8'h20);
    strobe(8'h00, HOLD);
    check("half_sq_im", LED, 8'h20);

    enter4(8'h80, 8'h00, 8'h80, 8'h00);
    check("neg1_sq_sat_re", LED, 8'h7F);
    check("model_neg1_sq_re", exp_led, 8'h7F);
    strobe(8'h00, HOLD);
    check("neg1_sq_im", LED, 8'h00);

    enter4(8'h00, 8'h40, 8'h00, 8'h40);
    check("j_half_sq_re", LED, 8'hE0);
    check("model_j_half_sq_re", exp_led, 8'hE0);
    strobe(8'h00, HOLD);
    check("j_half_sq_im", LED, 8'h00);

    enter4(8'h01, 8'h00, 8'hFF, 8'h00);
    check("floor_neg_lsb_re", LED, 8'hFF);
    check("model_floor_neg_re", exp_led, 8'hFF);
    strobe(8'h00, HOLD);
    enter4(8'h01, 8'h00, 8'h01, 8'h00);
    check("trunc_pos_lsb_re", LED, 8'h00);

    strobe(8'h00, HOLD);
    strobe(8'h11, HOLD);
    strobe(8'h22, HOLD);
    pulse_reset();
    check("mid_reset_led", LED, 8'h00);
    enter4(8'h20, 8'h10, 8'h40, 8'h60);
    check("post_reset_re", LED, 8'h04);
    check("model_post_reset_re", exp_led, 8'h04);
    strobe(8'h00, HOLD);
    check("post_reset_im", LED, 8'h20);

    pulse_reset();
    strobe(8'h40, 200);
    check("long_hold_load_led", LED, 8'h00);
    strobe(8'h00, HOLD);
    strobe(8'h40, HOLD);
    strobe(8'h40, HOLD);
    check("long_hold_one_capture_re", LED, 8'h20);
    strobe(8'h00, HOLD);
    check("long_hold_one_capture_im", LED, 8'h20);

`ifdef SM_DEBOUNCE_EN
    pulse_reset();
    glitch(8'h7F, 5);
    check("glitch_led", LED, 8'h00);
    enter4(8'h40, 8'h40, 8'h40, 8'h00);
    check("glitch_ignored_re", LED, 8'h20);
`endif

    valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmplx_mult_sm.md
Name: cmplx_mult_sm

Overview:
- Board-level switch/LED front end for a fixed-point complex multiplier.
- The operator enters four signed words one at a time on the switches, strobing a handshake switch for each: re_a, im_a, re_q, im_q.
- The block computes (re_a + j·im_a)·(re_q + j·im_q) and shows the real part on the LEDs, then the imaginary part after one more handshake strobe.
- Top-level block; the only ports are the board clock, switches and LEDs.

Parameters:
- WORD_W, 8, data word width; LED width; the switch bus is WORD_W+2 bits wide.
- FRAC_BITS, WORD_W-1, fractional bits of the signed fixed-point format (Q1.7 by default).
- DEBOUNCE_CYCLES, 16, required stable-high cycles on handshake when SM_DEBOUNCE_EN is defined.

Ports:
- clk  in  1  board clock; all logic on its rising edge.
- SW  in  WORD_W+2  switch bus:
  - SW[WORD_W+1] = reset_n: synchronous, active-low reset.
  - SW[WORD_W] = handshake strobe.
  - SW[WORD_W-1:0] = data_in, a signed two's-complement word.
- LED  out  WORD_W  result display.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = LOAD_RE_A, LED = 0, operand and result registers = 0, synchronizer = 0.
  - All registers also power up to these values; no clock edge may occur during the first reset.
- Reset mid-operation discards any partial entry and returns to LOAD_RE_A.
- Handshake path:
  - handshake passes through a 2-flop synchronizer, then a rising-edge detector.
  - One accepted edge = one event. Falling edges, and a level held high, generate nothing.
- On an event, data_in is sampled in the same cycle as the detected edge. The operator keeps data_in stable for at least 4 cycles after raising handshake.
- State machine (transitions only on events; otherwise hold):
  - LOAD_RE_A: capture re_a → LOAD_IM_A.
  - LOAD_IM_A: capture im_a → LOAD_RE_Q.
  - LOAD_RE_Q: capture re_q → LOAD_IM_Q.
  - LOAD_IM_Q: capture im_q, start compute → SHOW_RE.
  - SHOW_RE: → SHOW_IM.
  - SHOW_IM: capture data_in as the new re_a → LOAD_IM_A. Back-to-back products need no extra strobe.
- Arithmetic:
  - Compute pr = re_a·re_q − im_a·im_q and pi = re_a·im_q + im_a·re_q at full precision (2·WORD_W+1 bits).
  - Arithmetic shift right by FRAC_BITS, i.e. truncate toward −inf.
  - Saturate to [−2^(WORD_W−1), 2^(WORD_W−1)−1].
  - Results are registered 1 cycle after the im_q capture. LED holds the real result no later than 2 cycles after entering SHOW_RE.
- LED output, registered:
  - 0 in all LOAD states.
  - Saturated real result in SHOW_RE.
  - Saturated imaginary result in SHOW_IM, updated within 2 cycles of the SHOW_IM entry event.

Optional Feature:
- Macro SM_DEBOUNCE_EN.
- Defined: the synchronized handshake must be continuously high for DEBOUNCE_CYCLES cycles before an event fires. Exactly one event fires per high period, and any low sample restarts the count. data_in is sampled when the event fires.
- Undefined: events fire on the raw synchronized rising edge, as above.

Test Plan:
- Reset, then enter 0x40, 0x40, 0x40, 0x00 → LED = 0x20; strobe → LED = 0x20.
- Enter 0x80, 0x00, 0x80, 0x00 ((−1)·(−1)) → LED = 0x7F (saturated); strobe → LED = 0x00.
- Enter 0x00, 0x40, 0x00, 0x40 ((0.5j)²) → LED = 0xE0; strobe → 0x00.
- Enter 0x01, 0x00, 0xFF, 0x00 → LED = 0xFF (floor of −1/128); repeat with 0x01, 0x00, 0x01, 0x00 → LED = 0x00.
- Enter two words, assert reset_n = 0 for one cycle → LED = 0, state LOAD_RE_A; then a full 4-word entry gives the correct result.
- Hold handshake high for 200 cycles in LOAD_RE_A → exactly one word captured. With SM_DEBOUNCE_EN, a 5-cycle high glitch → no capture.
